parity_framer: RTL

PARITY_FRAMER -- requirements
Module: parity_framer

---
 rtl/parity_framer.sv | 94 +++++++++
 1 files changed

// File: rtl/parity_framer.sv
// rtl/parity_framer.sv - serial parity framer: latches {din, p} and shifts payload then parity on bit_tick.
// Optional error injection via `PARITY_ERR_INJ_EN (adds err_inj input that inverts p at acceptance).
module parity_framer #(
  parameter int DATA_W    = 7,
  parameter int ODD_PAR   = 0,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef PARITY_ERR_INJ_EN
  input  logic              err_inj,
`endif
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              bit_tick,
  output logic              sdo,
  output logic [DATA_W:0]   frame_out,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W:0]   sh_q;
  logic [DATA_W:0]   frame_q;
  logic              sdo_q;
  logic              done_q;

  logic              par_d;
  logic [DATA_W-1:0] din_ord_d;
  logic [DATA_W:0]   ser_d;
  logic [DATA_W:0]   frame_d;

  // ser_d holds the frame in transmit order, first bit at the MSB.
  always_comb begin
    par_d = en ? ((^din) ^ (ODD_PAR != 0)) : 1'b0;
`ifdef PARITY_ERR_INJ_EN
    par_d = par_d ^ err_inj;
`endif
    din_ord_d = din;
    if (MSB_FIRST == 0) begin
      for (int i = 0; i < DATA_W; i++) begin
        din_ord_d[DATA_W-1-i] = din[i];
      end
    end
    frame_d = {din, par_d};
    ser_d   = {din_ord_d, par_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      frame_q <= '0;
      sdo_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (din_valid) begin
          frame_q <= frame_d;
          sdo_q   <= ser_d[DATA_W];
          sh_q    <= {ser_d[DATA_W-1:0], 1'b0};
          cnt_q   <= CW'(DATA_W);
          state_q <= SHIFT;
        end
      end else if (bit_tick) begin
        if (cnt_q != '0) begin
          sdo_q <= sh_q[DATA_W];
          sh_q  <= {sh_q[DATA_W-1:0], 1'b0};
          cnt_q <= cnt_q - CW'(1);
        end else begin
          state_q <= IDLE;
          sdo_q   <= 1'b0;
          done_q  <= 1'b1;
        end
      end
    end
  end

  assign din_ready = (state_q == IDLE);
  assign busy      = (state_q == SHIFT);
  assign sdo       = sdo_q;
  assign frame_out = frame_q;
  assign done      = done_q;

endmodule
